// File: rtl/nb_alu_pkg.sv
// Shared widths and opcode encodings for the nb-core execute-stage ALU.
package nb_alu_pkg;

   localparam int unsigned XLEN         = 64;
   localparam int unsigned ALU_OP_WIDTH = 5;

   typedef enum logic [ALU_OP_WIDTH-1:0] {
      ALU_ADD  = 5'd0,
      ALU_SUB  = 5'd1,
      ALU_AND  = 5'd2,
      ALU_OR   = 5'd3,
      ALU_XOR  = 5'd4,
      ALU_SLL  = 5'd5,
      ALU_SRL  = 5'd6,
      ALU_SRA  = 5'd7,
      ALU_SLT  = 5'd8,
      ALU_SLTU = 5'd9,
      ALU_MUL  = 5'd10,
      ALU_DIV  = 5'd11,
      ALU_DIVU = 5'd12,
      ALU_REM  = 5'd13,
      ALU_REMU = 5'd14
   } alu_op_e;

endpackage

// File: rtl/nb_alu_muldiv.sv
// Combinational RV64M multiply/divide/remainder, including the divide-by-zero
// and signed-overflow results; used only when NB_ALU_MULDIV_EN is defined.
module nb_alu_muldiv
   import nb_alu_pkg::*;
#(
   parameter int unsigned W      = XLEN,
   parameter int unsigned OP_W   = ALU_OP_WIDTH
) (
   input  logic [W-1:0]    a,
   input  logic [W-1:0]    b,
   input  logic [OP_W-1:0] op,
   output logic [W-1:0]    result_c
);

   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   logic          div_zero;
   logic          sdiv_ovf;
   logic          div_guard;
   logic [W-1:0]  quo_s;
   logic [W-1:0]  rem_s;
   logic [W-1:0]  quo_u;
   logic [W-1:0]  rem_u;

   assign div_zero  = (b == '0);
   assign sdiv_ovf  = (a == MIN_NEG) && (b == '1);
   assign div_guard = div_zero || sdiv_ovf;

   // Dividers only see legal operands; special cases are selected below.
   assign quo_s = div_guard ? '0 : W'($unsigned($signed(a) / $signed(b)));
   assign rem_s = div_guard ? '0 : W'($unsigned($signed(a) % $signed(b)));
   assign quo_u = div_zero  ? '0 : a / b;
   assign rem_u = div_zero  ? '0 : a % b;

   always_comb begin
      result_c = '0;
      case (op)
         ALU_MUL:  result_c = a * b;
         ALU_DIV:  result_c = div_zero ? '1 : (sdiv_ovf ? a : quo_s);
         ALU_DIVU: result_c = div_zero ? '1 : quo_u;
         ALU_REM:  result_c = div_zero ? a  : (sdiv_ovf ? '0 : rem_s);
         ALU_REMU: result_c = div_zero ? a  : rem_u;
         default:  result_c = '0;
      endcase
   end

endmodule

// File: rtl/nb_alu.sv
// Registered 64-bit RV64I/RV64M ALU. Define NB_ALU_MULDIV_EN to build the
// multiply/divide unit; otherwise opcodes 10-14 return 0.
module nb_alu #(
   parameter int unsigned XLEN         = nb_alu_pkg::XLEN,
   parameter int unsigned ALU_OP_WIDTH = nb_alu_pkg::ALU_OP_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic [XLEN-1:0]         a,
   input  logic [XLEN-1:0]         b,
   input  logic [ALU_OP_WIDTH-1:0] alu_op,
   output logic [XLEN-1:0]         result,
   output logic                    zero,
   output logic                    out_valid
);

   import nb_alu_pkg::*;

   logic [5:0]      shamt;
   logic [XLEN-1:0] muldiv_c;
   logic [XLEN-1:0] result_d;

   assign shamt = b[5:0];

`ifdef NB_ALU_MULDIV_EN
   nb_alu_muldiv #(
      .W    (XLEN),
      .OP_W (ALU_OP_WIDTH)
   ) u_muldiv (
      .a        (a),
      .b        (b),
      .op       (alu_op),
      .result_c (muldiv_c)
   );
`else
   assign muldiv_c = '0;
`endif

   // Base-op select; unused opcodes fall through to zero.
   always_comb begin
      result_d = '0;
      case (alu_op)
         ALU_ADD:  result_d = a + b;
         ALU_SUB:  result_d = a - b;
         ALU_AND:  result_d = a & b;
         ALU_OR:   result_d = a | b;
         ALU_XOR:  result_d = a ^ b;
         ALU_SLL:  result_d = a << shamt;
         ALU_SRL:  result_d = a >> shamt;
         ALU_SRA:  result_d = XLEN'($unsigned($signed(a) >>> shamt));
         ALU_SLT:  result_d = XLEN'($signed(a) < $signed(b));
         ALU_SLTU: result_d = XLEN'(a < b);
         ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU:
                   result_d = muldiv_c;
         default:  result_d = '0;
      endcase
   end

   // Result loads every cycle; in_valid only qualifies out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result    <= '0;
         out_valid <= 1'b0;
      end else begin
         result    <= result_d;
         out_valid <= in_valid;
      end
   end

   assign zero = (result == '0);

endmodule

// File: tb/tb_nb_alu.sv
// Directed self-checking bench for nb_alu; mul/div expectations follow
// whether NB_ALU_MULDIV_EN is defined for the build.
module tb_nb_alu;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [63:0] a;
   logic [63:0] b;
   logic [4:0]  alu_op;
   logic [63:0] result;
   logic        zero;
   logic        out_valid;

   int n_cmp;
   int n_bad;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

   nb_alu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .alu_op    (alu_op),
      .result    (result),
      .zero      (zero),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One op per cycle: drive on the falling edge, check just after the rising edge.
   task automatic op(input string tag, input logic [4:0] code, input logic [63:0] va,
                     input logic [63:0] vb, input logic vld, input logic [63:0] exp);
      @(negedge clk);
      alu_op   = code;
      a        = va;
      b        = vb;
      in_valid = vld;
      @(posedge clk);
      #1;
      check64(tag, result, exp);
      check1({tag, ".zero"}, zero, exp == 64'd0);
      check1({tag, ".vld"}, out_valid, vld);
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      alu_op   = '0;
      #12;
      check64("rst.result", result, 64'd0);
      check1("rst.zero", zero, 1'b1);
      check1("rst.vld", out_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      op("add",      5'd0, 64'd10, 64'd20, 1'b1, 64'd30);
      op("add_wrap", 5'd0, ONES, 64'd1, 1'b1, 64'd0);
      op("sub_wrap", 5'd1, 64'd0, 64'd1, 1'b1, ONES);
      op("and",  5'd2, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 64'd0);
      op("or",   5'd3, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, ONES);
      op("xor",  5'd4, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, ONES);
      op("sll",  5'd5, 64'd1, 64'd4, 1'b1, 64'h10);
      op("srl",  5'd6, MINN, 64'd4, 1'b1, 64'h0800_0000_0000_0000);
      op("sra",  5'd7, MINN, 64'd4, 1'b1, 64'hF800_0000_0000_0000);
      op("sll68", 5'd5, 64'd1, 64'd68, 1'b1, 64'h10);
      op("slt_t",  5'd8, 64'hFFFF_FFFF_FFFF_FFF6, 64'd5, 1'b1, 64'd1);
      op("slt_f",  5'd8, 64'd5, 64'hFFFF_FFFF_FFFF_FFF6, 1'b1, 64'd0);
      op("sltu_t", 5'd9, 64'd5, 64'd10, 1'b1, 64'd1);
      op("sltu_f", 5'd9, ONES, 64'd10, 1'b1, 64'd0);

`ifdef NB_ALU_MULDIV_EN
      op("mul",     5'd10, 64'hFFFF_FFFF_FFFF_FFF6, 64'd20, 1'b1, 64'hFFFF_FFFF_FFFF_FF38);
      op("div",     5'd11, 64'hFFFF_FFFF_FFFF_FF9C, 64'd10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF6);
      op("rem",     5'd13, 64'd107, 64'd10, 1'b1, 64'd7);
      op("remu",    5'd14, 64'd107, 64'd10, 1'b1, 64'd7);
      op("rem_neg", 5'd13, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, ONES);
      op("divu",    5'd12, ONES, 64'd2, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF);
      op("div0",    5'd11, 64'd123, 64'd0, 1'b1, ONES);
      op("divu0",   5'd12, 64'd5, 64'd0, 1'b1, ONES);
      op("rem0",    5'd13, 64'd7, 64'd0, 1'b1, 64'd7);
      op("remu0",   5'd14, 64'd9, 64'd0, 1'b1, 64'd9);
      op("div_ovf", 5'd11, MINN, ONES, 1'b1, MINN);
      op("rem_ovf", 5'd13, MINN, ONES, 1'b1, 64'd0);
`else
      op("mul_off",  5'd10, 64'd10, 64'd20, 1'b1, 64'd0);
      op("div_off",  5'd11, 64'd100, 64'd10, 1'b1, 64'd0);
      op("rem0_off", 5'd13, 64'd7, 64'd0, 1'b1, 64'd0);
      op("add_on",   5'd0, 64'd10, 64'd20, 1'b1, 64'd30);
`endif

      op("op15", 5'd15, 64'd3, 64'd4, 1'b1, 64'd0);
      op("op31", 5'd31, 64'd3, 64'd4, 1'b1, 64'd0);

      // Full-rate back-to-back with toggling in_valid.
      op("b2b_add", 5'd0, 64'd1, 64'd2, 1'b1, 64'd3);
      op("b2b_xor", 5'd4, 64'hF0, 64'h0F, 1'b0, 64'hFF);
      op("b2b_sub", 5'd1, 64'd9, 64'd4, 1'b1, 64'd5);
      op("b2b_sll", 5'd5, 64'd3, 64'd8, 1'b0, 64'h300);
      op("b2b_or",  5'd3, 64'd0, 64'd0, 1'b1, 64'd0);

      // Asynchronous reset in the middle of a cycle.
      op("pre_rst", 5'd0, 64'd40, 64'd2, 1'b1, 64'd42);
      #2;
      rst_n = 1'b0;
      #1;
      check64("mid_rst.result", result, 64'd0);
      check1("mid_rst.zero", zero, 1'b1);
      check1("mid_rst.vld", out_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      op("post_rst", 5'd0, 64'd10, 64'd20, 1'b1, 64'd30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
